// File: rtl/xor_req_scheduler_pkg.sv
// xor_req_scheduler_pkg
//   Shared types and sizing helpers for the XOR request scheduler.
//   - state_t   : scheduler FSM states, 3-bit encoding
//   - id_width  : width of a requester index for n requesters
//   - cnt_width : width of a counter that must hold 0..max_val
package xor_req_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DELAY = 3'd3,
    RESP  = 3'd4
  } state_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/xor_req_scheduler_if.sv
// xor_req_scheduler_if
//   Bundles the request, response and delayed_dut signals of the scheduler.
//   Ports (signals):
//     req_valid/req_ready/req_data : per-requester request handshake and operands
//     rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err : tagged response handshake
//     dut_din/dut_wr_en/dut_dout/dut_rd_en : link to the shared delayed_dut
//   Modports:
//     slave  : the scheduler itself
//     master : requesters, response consumer and delayed_dut seen together
interface xor_req_scheduler_if
  import xor_req_scheduler_pkg::*;
#(
  parameter int N_REQ = 4
);
  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [2*N_REQ-1:0] req_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_data;
  logic               rsp_err;
  logic [1:0]         dut_din;
  logic               dut_wr_en;
  logic [1:0]         dut_dout;
  logic               dut_rd_en;

  modport slave (
    input  req_valid, req_data, rsp_ready, dut_dout, dut_rd_en,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, dut_din, dut_wr_en
  );

  modport master (
    output req_valid, req_data, rsp_ready, dut_dout, dut_rd_en,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, dut_din, dut_wr_en
  );

endinterface

// File: rtl/xor_req_scheduler_rr_arbiter.sv
// xor_req_scheduler_rr_arbiter
//   Purely combinational round-robin pick among N_REQ request lines.
//   Ports:
//     req       in  N_REQ  pending requests
//     rr_ptr    in  ID_W   index with highest priority this cycle
//     grant     out N_REQ  one-hot grant, zero when nothing is pending
//     grant_idx out ID_W   index of the granted requester
//     grant_vld out 1      some requester was granted
module xor_req_scheduler_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_vld
);

  logic [ID_W-1:0] idx;

  // Scan rr_ptr, rr_ptr+1 ... modulo N_REQ and keep the first pending one.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ID_W'((int'(rr_ptr) + i) % N_REQ);
      if (!grant_vld && req[idx]) begin
        grant_vld  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/xor_req_scheduler.sv
// xor_req_scheduler
//   Shares one delayed_dut XOR datapath between N_REQ requesters. One request
//   is accepted at a time by round-robin, written to the DUT, and the result is
//   sampled RESULT_DELAY cycles after dut_rd_en. A missing dut_rd_en for
//   TIMEOUT cycles yields an error response instead.
//   Ports:
//     clk   in   clock, all logic on posedge
//     rst   in   synchronous active-high reset
//     bus   slave modport of xor_req_scheduler_if (request/response/DUT link)
//     busy  out  high whenever the FSM is not in IDLE
module xor_req_scheduler
  import xor_req_scheduler_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int RESULT_DELAY = 1,
  parameter int TIMEOUT      = 15
) (
  input  logic                clk,
  input  logic                rst,
  xor_req_scheduler_if.slave  bus,
  output logic                busy
);

  localparam int ID_W   = id_width(N_REQ);
  localparam int WAIT_W = cnt_width(TIMEOUT);
  localparam int DLY_W  = cnt_width(RESULT_DELAY);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   id_q;
  logic [1:0]        data_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [DLY_W-1:0]  dly_cnt_q;
  logic              rsp_data_q;
  logic              rsp_err_q;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_vld;
  logic [1:0]        sel_data;
  logic              timeout_hit;
  logic              dly_done;

  xor_req_scheduler_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Operand slice of whichever requester the arbiter picked.
  always_comb begin
    sel_data = 2'b00;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_data = bus.req_data[2*i +: 2];
    end
  end

  assign timeout_hit = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));
  assign dly_done    = (dly_cnt_q == DLY_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and all outputs; response fields are only driven in RESP so
  // the bus reads zero whenever no response is being offered.
  always_comb begin
    state_d       = state_q;
    busy          = (state_q != IDLE);
    bus.req_ready = '0;
    bus.dut_wr_en = 1'b0;
    bus.dut_din   = 2'b00;
    bus.rsp_valid = 1'b0;
    bus.rsp_id    = '0;
    bus.rsp_data  = 1'b0;
    bus.rsp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = grant;
        if (grant_vld) state_d = ISSUE;
      end
      ISSUE: begin
        bus.dut_wr_en = 1'b1;
        bus.dut_din   = data_q;
        state_d       = WAIT;
      end
      WAIT: begin
        if (bus.dut_rd_en) state_d = (RESULT_DELAY == 0) ? RESP : DELAY;
        else if (timeout_hit) state_d = RESP;
      end
      DELAY: begin
        if (dly_done) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_id    = id_q;
        bus.rsp_data  = rsp_data_q;
        bus.rsp_err   = rsp_err_q;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transaction registers. rr_ptr only moves on a completed response, which
  // keeps every pending requester guaranteed a turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      id_q       <= '0;
      data_q     <= 2'b00;
      wait_cnt_q <= '0;
      dly_cnt_q  <= '0;
      rsp_data_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            id_q       <= grant_idx;
            data_q     <= sel_data;
            rsp_data_q <= 1'b0;
            rsp_err_q  <= 1'b0;
          end
        end
        ISSUE: wait_cnt_q <= '0;
        WAIT: begin
          if (bus.dut_rd_en) begin
            dly_cnt_q <= DLY_W'(RESULT_DELAY);
            if (RESULT_DELAY == 0) rsp_data_q <= bus.dut_dout[0];
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            if (timeout_hit) begin
              rsp_err_q  <= 1'b1;
              rsp_data_q <= 1'b0;
            end
          end
        end
        DELAY: begin
          dly_cnt_q <= dly_cnt_q - DLY_W'(1);
          if (dly_done) rsp_data_q <= bus.dut_dout[0];
        end
        RESP: begin
          if (bus.rsp_ready)
            rr_ptr_q <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
